// File: rtl/cnn_flatten_pkg.sv
// Shared types and constants for the pooled-buffer flatten sequencer.
package cnn_flatten_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } flatten_state_t;

  // Output FIFO depth; together with the credit rule this bounds the
  // number of elements buffered or in flight.
  localparam int FLATTEN_FIFO_DEPTH = 2;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flatten_out_fifo.sv
// Two-entry output FIFO holding {data, index, last} for the flattened stream.
module flatten_out_fifo
  import cnn_flatten_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 1,
  parameter int COUNT_W = $clog2(FLATTEN_FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic [INDEX_W-1:0] push_index,
  input  logic               push_last,
  input  logic               pop,
  output logic [COUNT_W-1:0] count,
  output logic               not_empty,
  output logic [DATA_W-1:0]  head_data,
  output logic [INDEX_W-1:0] head_index,
  output logic               head_last
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [INDEX_W-1:0] index;
    logic               last;
  } entry_t;

  localparam int PTR_W = idx_width(FLATTEN_FIFO_DEPTH);

  entry_t           mem [FLATTEN_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the storage is reset (cheap at two entries) so the head
      // outputs read as zero right after reset instead of stale data.
      for (int i = 0; i < FLATTEN_FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{data: push_data, index: push_index, last: push_last};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + COUNT_W'(push) - COUNT_W'(pop);
    end
  end

  assign not_empty  = (count != '0);
  assign head_data  = mem[rd_ptr].data;
  assign head_index = mem[rd_ptr].index;
  assign head_last  = mem[rd_ptr].last;

endmodule

// File: rtl/flatten_sequencer.sv
// Walks the pooled feature-map buffer and streams it out as a flattened
// vector, one element per cycle, with a credit-limited read pipeline.
// Build option: define FLATTEN_CHANNEL_LAST_EN for row/col/feature
// (channel-last) traversal; otherwise feature/row/col order.
module flatten_sequencer
  import cnn_flatten_pkg::*;
#(
  parameter int NUM_FEATURES           = 10,
  parameter int POOLED_HEIGHT          = 10,
  parameter int POOLED_WIDTH           = 10,
  parameter int FLATTENED_LENGTH       = 10,
  parameter int CONVOLUTION_DATA_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flatten_start,
  output logic                                    pooled_rd_en,
  output logic [idx_width(NUM_FEATURES)-1:0]      pooled_rd_feature,
  output logic [idx_width(POOLED_HEIGHT)-1:0]     pooled_rd_row,
  output logic [idx_width(POOLED_WIDTH)-1:0]      pooled_rd_col,
  input  logic [CONVOLUTION_DATA_WIDTH-1:0]       pooled_rd_data,
  output logic                                    flat_valid,
  input  logic                                    flat_ready,
  output logic [CONVOLUTION_DATA_WIDTH-1:0]       flat_data,
  output logic [idx_width(FLATTENED_LENGTH)-1:0]  flat_index,
  output logic                                    flat_last,
  output logic                                    flatten_busy,
  output logic                                    flatten_done
);

  localparam int FW   = idx_width(NUM_FEATURES);
  localparam int RW   = idx_width(POOLED_HEIGHT);
  localparam int CW   = idx_width(POOLED_WIDTH);
  localparam int IW   = idx_width(FLATTENED_LENGTH);
  localparam int CNTW = $clog2(FLATTEN_FIFO_DEPTH + 1);

  localparam logic [FW-1:0] FEAT_MAX = FW'(NUM_FEATURES - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(POOLED_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(POOLED_WIDTH - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(FLATTENED_LENGTH - 1);

  if (FLATTENED_LENGTH != NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH) begin : g_len_check
    $error("FLATTENED_LENGTH must equal NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH");
  end

  flatten_state_t state, state_next;
  logic [FW-1:0]  feat, feat_next;
  logic [RW-1:0]  row, row_next;
  logic [CW-1:0]  col, col_next;
  logic [IW-1:0]  idx;
  logic           rd_en, clear, is_final;
  logic           inflight, inflight_last;
  logic [IW-1:0]  inflight_index;
  logic [CNTW-1:0] fifo_count;
  logic           fifo_valid, head_last, pop, credit_ok;
  logic [CNTW:0]  occupancy;

  assign pop       = fifo_valid & flat_ready;
  assign occupancy = (CNTW+1)'(fifo_count) + (CNTW+1)'(inflight) - (CNTW+1)'(pop);
  assign credit_ok = (occupancy < (CNTW+1)'(FLATTEN_FIFO_DEPTH));
  assign is_final  = (feat == FEAT_MAX) && (row == ROW_MAX) && (col == COL_MAX);

  // Next traversal position after the current read.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no latch can be inferred on an unassigned path.
    feat_next = feat;
    row_next  = row;
    col_next  = col;
`ifdef FLATTEN_CHANNEL_LAST_EN
    if (feat == FEAT_MAX) begin
      feat_next = '0;
      if (col == COL_MAX) begin
        col_next = '0;
        row_next = row + RW'(1);
      end else begin
        col_next = col + CW'(1);
      end
    end else begin
      feat_next = feat + FW'(1);
    end
`else
    if (col == COL_MAX) begin
      col_next = '0;
      if (row == ROW_MAX) begin
        row_next  = '0;
        feat_next = feat + FW'(1);
      end else begin
        row_next = row + RW'(1);
      end
    end else begin
      col_next = col + CW'(1);
    end
`endif
  end

  // FSM next state and control strobes.
  always_comb begin
    state_next   = state;
    rd_en        = 1'b0;
    clear        = 1'b0;
    flatten_busy = 1'b0;
    flatten_done = 1'b0;
    case (state)
      IDLE: begin
        if (flatten_start) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        flatten_busy = 1'b1;
        rd_en        = credit_ok;
        if (rd_en && is_final) state_next = DRAIN;
      end
      DRAIN: begin
        flatten_busy = 1'b1;
        if (pop && head_last) state_next = DONE;
      end
      DONE: begin
        flatten_done = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values and updates together.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Traversal and flat-index counters, advanced once per issued read.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      feat <= '0;
      row  <= '0;
      col  <= '0;
      idx  <= '0;
    end else if (rd_en) begin
      feat <= feat_next;
      row  <= row_next;
      col  <= col_next;
      idx  <= idx + IW'(1);
    end
  end

  // Tag of the read in flight; its data returns on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight       <= 1'b0;
      inflight_index <= '0;
      inflight_last  <= 1'b0;
    end else begin
      inflight       <= rd_en;
      inflight_index <= idx;
      inflight_last  <= (idx == IDX_MAX);
    end
  end

  flatten_out_fifo #(
    .DATA_W  (CONVOLUTION_DATA_WIDTH),
    .INDEX_W (IW),
    .COUNT_W (CNTW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_data  (pooled_rd_data),
    .push_index (inflight_index),
    .push_last  (inflight_last),
    .pop        (pop),
    .count      (fifo_count),
    .not_empty  (fifo_valid),
    .head_data  (flat_data),
    .head_index (flat_index),
    .head_last  (head_last)
  );

  assign pooled_rd_en      = rd_en;
  assign pooled_rd_feature = feat;
  assign pooled_rd_row     = row;
  assign pooled_rd_col     = col;
  assign flat_valid        = fifo_valid;
  assign flat_last         = head_last;

endmodule

// File: tb/tb_flatten_sequencer.sv
// Self-checking bench for flatten_sequencer with F=2, H=2, W=3 (L=12).
module tb_flatten_sequencer;
  import cnn_flatten_pkg::*;

  localparam int F = 2, H = 2, W = 3, L = 12;

  logic       clk = 1'b0;
  logic       reset, flatten_start, flat_ready;
  logic       pooled_rd_en;
  logic [0:0] pooled_rd_feature, pooled_rd_row;
  logic [1:0] pooled_rd_col;
  logic [7:0] pooled_rd_data = 8'h00;
  logic       flat_valid, flat_last, flatten_busy, flatten_done;
  logic [7:0] flat_data;
  logic [3:0] flat_index;

  always #5 clk = ~clk;

  flatten_sequencer #(
    .NUM_FEATURES (F), .POOLED_HEIGHT (H), .POOLED_WIDTH (W),
    .FLATTENED_LENGTH (L), .CONVOLUTION_DATA_WIDTH (8)
  ) dut (
    .clk (clk), .reset (reset), .flatten_start (flatten_start),
    .pooled_rd_en (pooled_rd_en), .pooled_rd_feature (pooled_rd_feature),
    .pooled_rd_row (pooled_rd_row), .pooled_rd_col (pooled_rd_col),
    .pooled_rd_data (pooled_rd_data), .flat_valid (flat_valid),
    .flat_ready (flat_ready), .flat_data (flat_data), .flat_index (flat_index),
    .flat_last (flat_last), .flatten_busy (flatten_busy), .flatten_done (flatten_done)
  );

  // Pooled buffer model: element (f,r,c) holds 16f+4r+c, one-cycle read latency.
  always @(posedge clk)
    pooled_rd_data <= pooled_rd_en ?
      8'(16 * int'(pooled_rd_feature) + 4 * int'(pooled_rd_row) + int'(pooled_rd_col)) : 8'h00;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] index;
    logic       last;
  } elem_t;

  logic [7:0] exp_data [L];
  elem_t      sb_q [$];
  elem_t      sb_head, prev_elem;
  logic       prev_stall = 1'b0;
  int         rd_cnt = 0, acc_cnt = 0, done_cnt = 0;

  task automatic push_expected();
    for (int k = 0; k < L; k++) sb_q.push_back('{exp_data[k], 4'(k), (k == L - 1)});
  endtask

  task automatic clear_stats();
    sb_q.delete();
    rd_cnt   = 0;
    acc_cnt  = 0;
    done_cnt = 0;
  endtask

  // Monitor: scoreboard, stall stability and outstanding-read bound.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", flat_valid, 1);
        check("stall_hold", {flat_data, flat_index, flat_last}, prev_elem);
      end
      if (pooled_rd_en) rd_cnt++;
      if (flatten_done) done_cnt++;
      if (flat_valid && flat_ready) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_element", {flat_data, flat_index, flat_last}, 0);
        end else begin
          sb_head = sb_q.pop_front();
          check("sb_element", {flat_data, flat_index, flat_last}, sb_head);
        end
      end
      if (pooled_rd_en || flat_valid) check("credit_bound", (rd_cnt - acc_cnt) <= 2, 1);
      prev_stall = flat_valid && !flat_ready;
      prev_elem  = {flat_data, flat_index, flat_last};
    end
  end

  task automatic step(input logic s, input logic r);
    @(negedge clk);
    flatten_start = s;
    flat_ready    = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; flatten_start = 1'b0; flat_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs until flatten_done; mode 1 alternates flat_ready, else holds it high.
  task automatic run_until_done(input string name, input int max_cycles, input int mode);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step(1'b0, (mode == 1) ? logic'(i % 2 == 0) : 1'b1);
      if (flatten_done) begin seen = 1'b1; break; end
    end
    check({name, "_done_seen"}, seen, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  function automatic logic [31:0] all_outputs();
    return {pooled_rd_en, pooled_rd_feature, pooled_rd_row, pooled_rd_col, flat_valid,
            flat_data, flat_index, flat_last, flatten_busy, flatten_done};
  endfunction

  typedef struct {
    logic       start;
    logic       ready;
    logic [4:0] flags;   // {rd_en, busy, valid, last, done}
    logic [7:0] data;
    logic [3:0] index;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Expected element order from the buffer model's own traversal.
    begin
      int k = 0;
`ifdef FLATTEN_CHANNEL_LAST_EN
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) for (int f = 0; f < F; f++) begin
        exp_data[k] = 8'(16 * f + 4 * r + c); k++;
      end
`else
      for (int f = 0; f < F; f++) for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
        exp_data[k] = 8'(16 * f + 4 * r + c); k++;
      end
`endif
    end

    // Cycle-accurate expectations with flat_ready held at 1, start in cycle 0.
    for (int i = 0; i < 17; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].ready = 1'b1;
      tbl[i].flags = {(i >= 1 && i <= L), (i >= 1 && i <= L + 2), (i >= 3 && i <= L + 2),
                      (i == L + 2), (i == L + 3)};
      tbl[i].data  = (i >= 3 && i <= L + 2) ? exp_data[i - 3] : 8'h00;
      tbl[i].index = 4'(i - 3);
    end

    reset = 1'b1; flatten_start = 1'b0; flat_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", all_outputs(), 0);
    @(negedge clk);
    reset = 1'b0;

    // Nominal stream, table driven.
    clear_stats();
    push_expected();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].start, tbl[i].ready);
      check($sformatf("cyc%0d_flags", i),
            {pooled_rd_en, flatten_busy, flat_valid, flat_last, flatten_done}, tbl[i].flags);
      if (tbl[i].flags[2]) begin
        check($sformatf("cyc%0d_data", i), flat_data, tbl[i].data);
        check($sformatf("cyc%0d_index", i), flat_index, tbl[i].index);
      end
    end
    step(1'b0, 1'b1);
    check("nominal_all_consumed", sb_q.size(), 0);
    check("nominal_reads", rd_cnt, L);
    check("nominal_done_pulses", done_cnt, 1);

    // Alternating back-pressure.
    do_reset();
    clear_stats();
    push_expected();
    step(1'b1, 1'b1);
    run_until_done("alt", 200, 1);
    check("alt_all_consumed", sb_q.size(), 0);
    check("alt_accepted", acc_cnt, L);
    check("alt_done_pulses", done_cnt, 1);

    // Consumer stalled from the start: only two reads may be issued.
    do_reset();
    clear_stats();
    push_expected();
    step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    check("stall_reads", rd_cnt, 2);
    check("stall_head_valid", flat_valid, 1);
    check("stall_head_index", flat_index, 0);
    run_until_done("stall", 100, 0);
    check("stall_all_consumed", sb_q.size(), 0);
    check("stall_total_reads", rd_cnt, L);

    // Start pulses in RUN (cycle 5) and in DONE (cycle 15) are ignored.
    do_reset();
    clear_stats();
    push_expected();
    step(1'b1, 1'b1);
    for (int c = 1; c < L + 3; c++) step(c == 5, 1'b1);
    step(1'b1, 1'b1);
    check("restart_done_cycle", flatten_done, 1);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1);
    check("restart_reads", rd_cnt, L);
    check("restart_done_pulses", done_cnt, 1);
    check("restart_idle_busy", flatten_busy, 0);
    check("restart_all_consumed", sb_q.size(), 0);

    // Reset in cycle 7, then a fresh run from index 0.
    do_reset();
    clear_stats();
    push_expected();
    step(1'b1, 1'b1);
    for (int c = 1; c < 7; c++) step(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_outputs", all_outputs(), 0);
    clear_stats();
    push_expected();
    step(1'b1, 1'b1);
    run_until_done("midreset", 50, 0);
    check("midreset_all_consumed", sb_q.size(), 0);
    check("midreset_reads", rd_cnt, L);
    check("midreset_done_pulses", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
